// File: rtl/sync_ram_pkg.sv
// Shared types and default widths for the synchronous RAM initiator.
package sync_ram_pkg;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3,
    INIT    = 3'd4
  } state_e;
endpackage

// File: rtl/sync_ram_initiator.sv
// Single-outstanding initiator for a synchronous single-port RAM: client
// reads/writes over valid/ready plus a fill engine that writes every location.
module sync_ram_initiator
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  input  logic [DATA_W-1:0] init_value,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e              state_q, state_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // In ACCESS, ram_we_q still carries the accepted request's direction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (init_start)     state_d = INIT;
        else if (req_valid) state_d = ACCESS;
      end
      ACCESS:  state_d = ram_we_q ? IDLE : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      INIT:    if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = init_value;
          cnt_d      = '0;
        end else if (req_valid) begin
          ram_we_d   = req_we;
          ram_addr_d = req_addr;
          if (req_we) ram_din_d = req_wdata;
        end
      end
      ACCESS: ram_we_d = 1'b0;
      CAPTURE: begin
        rsp_rdata_d = ram_dout;
        rsp_valid_d = 1'b1;
      end
      RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      INIT: begin
        // The last address ends the fill; the counter never wraps.
        if (cnt_q == LAST) begin
          ram_we_d = 1'b0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ram_addr_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !init_start;
  assign busy      = (state_q != IDLE);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sync_ram_initiator.sv
// Bench for sync_ram_initiator: golden RAM array, transaction-level model
// compared every cycle, directed scenarios and a randomized phase.
module tb_sync_ram_initiator;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, hold_rsp;
  logic [DW-1:0] rsp_rdata;
  logic          init_start;
  logic [DW-1:0] init_value;
  logic          busy, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];

  sync_ram_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .init_value(init_value), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Golden single-port RAM, read-first, registered output.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: when the controller is free, what the RAM port
  // must show, and which response is owed.
  int            free_at = 0;
  bit            rd_pend = 0;
  int            rd_at = -100;
  logic [DW-1:0] rd_data;
  int            wr_at = -100;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int            init_at = -100;
  logic [DW-1:0] init_val;
  int            we_cnt = 0, busy_cnt = 0, rsp_cnt = 0, lat = 0;
  logic [DW-1:0] last_rsp;
  logic          rv_prev = 1'b0;

  always @(negedge clk) begin
    bit            e_busy, e_we, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ram_we", 32'(ram_we), 32'(0));
      chk("rst_ram_addr", 32'(ram_addr), 32'(0));
      chk("rst_ram_din", 32'(ram_din), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
      rd_pend = 0; free_at = 0; wr_at = -100; init_at = -100;
    end else begin
      e_busy = rd_pend || (cyc < free_at);
      e_we   = (cyc == wr_at) || (cyc >= init_at && cyc < init_at + DEPTH);
      if (cyc == wr_at) begin
        e_addr = wr_addr; e_din = wr_data;
      end else begin
        e_addr = AW'(cyc - init_at); e_din = init_val;
      end
      e_rv = rd_pend && (cyc >= rd_at + 2);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("req_ready", 32'(req_ready), 32'(!e_busy && !init_start));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_we) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_din", 32'(ram_din), 32'(e_din));
        exp_mem[e_addr] = e_din;
      end
      if (e_rv) chk("rsp_rdata", 32'(rsp_rdata), 32'(rd_data));
      if (ram_we) we_cnt++;
      if (busy) busy_cnt++;
      if (rsp_valid && !rv_prev) lat = cyc - rd_at + 1;
      if (e_rv && rsp_ready) begin
        last_rsp = rsp_rdata; rsp_cnt++;
        rd_pend = 0; free_at = cyc + 1;
      end
      if (!e_busy && init_start) begin
        init_at = cyc + 1; init_val = init_value; free_at = cyc + 1 + DEPTH;
      end else if (!e_busy && req_valid) begin
        if (req_we) begin
          wr_at = cyc + 1; wr_addr = req_addr; wr_data = req_wdata; free_at = cyc + 2;
        end else begin
          rd_pend = 1; rd_at = cyc + 1; rd_data = exp_mem[req_addr];
        end
      end
    end
    rv_prev = rsp_valid;
  end

  // All driver tasks start and end at posedge+1.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic start_init(input logic [DW-1:0] v);
    init_start = 1'b1; init_value = v;
    @(posedge clk); #1;
    init_start = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    issue(1'b0, a, 8'($urandom));
    wait_idle();
  endtask

  initial begin
    int acc [4];
    int w0, b0, n0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(8'h11 * i);
      exp_mem[i] = DW'(8'h11 * i);
    end
    rst = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    init_start = 0; init_value = '0; hold_rsp = 0; rsp_ready = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read addr 5.
    issue(1'b1, 3'd5, 8'hA5);
    wait_idle();
    n0 = rsp_cnt;
    do_read(3'd5);
    chk("wr_rd_data", 32'(last_rsp), 32'(8'hA5));
    chk("rd_latency", 32'(lat), 32'(3));
    chk("one_rsp", 32'(rsp_cnt - n0), 32'(1));
    chk("mem5", 32'(mem[5]), 32'(8'hA5));

    // Read addr 2 with the response held back; init_start pulse is ignored.
    hold_rsp = 1'b1;
    issue(1'b0, 3'd2, 8'h00);
    repeat (3) @(posedge clk);
    #1 init_start = 1'b1; init_value = 8'hEE;
    @(posedge clk); #1 init_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 hold_rsp = 1'b0;
    wait_idle();
    chk("held_rd_data", 32'(last_rsp), 32'(8'h22));
    chk("no_fill_in_resp", 32'(mem[0]), 32'(8'h00));

    // Fill with 0x3C.
    w0 = we_cnt; b0 = busy_cnt;
    start_init(8'h3C);
    wait_idle();
    chk("init_we_cycles", 32'(we_cnt - w0), 32'(DEPTH));
    chk("init_busy_cycles", 32'(busy_cnt - b0), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      chk("init_readback", 32'(last_rsp), 32'(8'h3C));
    end

    // init_start beats a simultaneous write to addr 1.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'hFF;
    init_start = 1'b1; init_value = 8'h3C;
    mem[1] = 8'h00; exp_mem[1] = 8'h00;
    @(posedge clk); #1 init_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("collide_mem1_fill", 32'(mem[1]), 32'(8'h3C));
    @(posedge clk); #1 req_valid = 1'b0;
    wait_idle();
    chk("collide_mem1_write", 32'(mem[1]), 32'(8'hFF));

    // Back-to-back writes with req_valid held.
    req_valid = 1'b1; req_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = AW'(4 + k); req_wdata = DW'(8'hB0 + k);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      @(posedge clk); #1;
      acc[k] = cyc;
    end
    req_valid = 1'b0;
    wait_idle();
    for (int k = 0; k < 3; k++) chk("b2b_spacing", 32'(acc[k+1] - acc[k]), 32'(2));
    chk("b2b_mem7", 32'(mem[7]), 32'(8'hB3));

    // Reset in the middle of a fill at counter 3.
    start_init(8'h3C);
    wait_idle();
    start_init(8'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_addr", 32'(ram_addr), 32'(3));
    rst = 1'b1;
    #1;
    chk("rst_now_we", 32'(ram_we), 32'(0));
    chk("rst_now_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++)
      chk("rst_fill_mem", 32'(mem[i]), (i < 3) ? 32'(8'h5A) : 32'(8'h3C));
    @(posedge clk); #1;

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      int r = $urandom_range(0, 19);
      hold_rsp = ($urandom_range(0, 5) == 0);
      if (r == 0) begin
        wait_idle();
        start_init(8'($urandom));
        wait_idle();
      end else if (r < 10) begin
        issue(1'b1, 3'($urandom), 8'($urandom));
      end else begin
        issue(1'b0, 3'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 hold_rsp = 1'b0;
        wait_idle();
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    hold_rsp = 1'b0;
    wait_idle();
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(mem[i]), 32'(exp_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_ram_initiator.md
Name: sync_ram_initiator

Overview:
Initiator-side controller that drives the single-port synchronous RAM port (we/addr/din/dout) on behalf of a client. The client issues requests over a valid/ready handshake and receives read data over a valid/ready response channel. A built-in fill engine writes one value to every location. Sits between client logic and the RAM instance; it is the only driver of the RAM's we/addr/din.

Parameters:
ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W locations
DATA_W, 8, RAM data width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  client request valid
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  client accepts read data
rsp_rdata  output  DATA_W  read data
init_start  input  1  start fill of all locations
init_value  input  DATA_W  fill value, sampled with init_start
busy  output  1  high whenever FSM is not IDLE
ram_we  output  1  to RAM write enable
ram_addr  output  ADDR_W  to RAM address
ram_din  output  DATA_W  to RAM data in
ram_dout  input  DATA_W  from RAM; valid the cycle after a read edge

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; ram_we=0, ram_addr=0, ram_din=0; rsp_valid=0, rsp_rdata=0; init counter 0; busy=0. Reset does not touch RAM contents.
- All RAM-side outputs and all rsp outputs are registered. req_ready = (state==IDLE) && !init_start. busy = (state!=IDLE).
- States: IDLE, ACCESS, CAPTURE, RESP, INIT.
- IDLE, init_start=1: latch init_value; load counter 0; drive ram_we=1, ram_addr=0, ram_din=init_value; go to INIT. init_start wins over a simultaneous req_valid, and that request is not accepted.
- IDLE, req_valid=1 (accept edge E0): register ram_addr=req_addr, ram_we=req_we, ram_din=req_wdata (ram_din unchanged on reads); go to ACCESS.
- ACCESS (RAM acts on edge E1): ram_we<=0. Write: go to IDLE, and the next request may be accepted at E2 (1 write per 2 cycles). Read: go to CAPTURE.
- CAPTURE (edge E2): rsp_rdata<=ram_dout; rsp_valid<=1; go to RESP. rsp_valid first high in the cycle after E2, i.e. 3 cycles after accept.
- RESP: hold rsp_valid and rsp_rdata stable until rsp_valid && rsp_ready. On that edge rsp_valid<=0 and go to IDLE. Writes produce no response.
- INIT: one write per cycle, addresses 0..DEPTH-1 ascending, ram_we=1 continuously. On the edge where address DEPTH-1 is written, ram_we<=0 and go to IDLE. INIT lasts exactly DEPTH cycles. The counter must not wrap into a second pass.
- init_start outside IDLE is ignored, including while in INIT.
- ram_addr holds its last value while idle. With ram_we=0 the RAM performs harmless reads.
- Reset asserted mid-transaction or mid-INIT: outputs go immediately to reset values. The RAM is left partially written, no further writes occur, and any pending response is dropped.
- Only one transaction is ever outstanding. The response channel never drops or duplicates data.

Decomposition:
- Package sync_ram_pkg: state enum (IDLE, ACCESS, CAPTURE, RESP, INIT) and default ADDR_W/DATA_W constants.
- No sub-module. The bench instantiates sync_ram_initiator connected to the existing sync_ram as the golden memory.

Test Plan:
- Write addr 5 data 0xA5, then read addr 5 -> rsp_valid 3 cycles after the read accept, rsp_rdata=0xA5, no response for the write.
- Read addr 2 with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, then one handshake and return to IDLE.
- init_start with init_value 0x3C -> busy high 8 cycles, ram_we high 8 cycles at addrs 0..7, then reading each addr returns 0x3C.
- init_start and req_valid (write addr 1, 0xFF) in the same cycle -> fill runs, request not accepted; after fill, addr 1 reads 0x3C until the held request is accepted.
- Back-to-back writes with req_valid held high -> one accept every 2 cycles, ram_we pulses 1 cycle each.
- Assert rst during INIT at counter 3 -> ram_we=0 and busy=0 immediately; addrs 0..2 hold the fill value and addrs 4..7 are unchanged.
